// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - flag bit indices, opcode constants and shared enums for the flag/branch path
package flag_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_O = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 3;
    localparam int FLAG_I = 4;
    localparam int FLAG_A = 5;

    localparam logic [1:0] OP_BR_MSB = 2'b10;
    localparam logic [4:0] OP_RETI   = 5'h18;
    localparam logic [4:0] OP_LDFI   = 5'h19;
    localparam logic [4:0] OP_MOVF   = 5'h1A;

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_Z  = 3'd1,
        COND_NZ = 3'd2,
        COND_C  = 3'd3,
        COND_NC = 3'd4,
        COND_N  = 3'd5,
        COND_O  = 3'd6,
        COND_LT = 3'd7
    } cond_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fbc_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluation against the flag register
module branch_cond_eval
    import flag_pkg::*;
(
    input  logic [7:0] flags,
    input  cond_e      cond,
    output logic       taken
);

    // I, A and the spare bits never influence a branch decision
    logic unused_flags;
    assign unused_flags = ^flags[7:4];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_Z:  taken = flags[FLAG_Z];
            COND_NZ: taken = ~flags[FLAG_Z];
            COND_C:  taken = flags[FLAG_C];
            COND_NC: taken = ~flags[FLAG_C];
            COND_N:  taken = flags[FLAG_N];
            COND_O:  taken = flags[FLAG_O];
            COND_LT: taken = flags[FLAG_N] ^ flags[FLAG_O];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_ctrl.sv
// rtl/flag_branch_ctrl.sv - PC owner: conditional branches, RETI and maskable irq with one-cycle flush
// Optional taken-branch counter enabled by FLAG_BRANCH_PERF_EN.
module flag_branch_ctrl
    import flag_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = 'h00,
    parameter logic [PC_W-1:0] IRQ_VEC  = 'hF0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [4:0]      i,
    input  logic [7:0]      imm,
    input  logic [7:0]      flags,
    input  logic            stall,
    input  logic            irq,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            irq_ack,
    output logic            clr_i,
    output logic [PC_W-1:0] epc
`ifdef FLAG_BRANCH_PERF_EN
    ,
    output logic [15:0]     br_taken_cnt
`endif
);

    fbc_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_d, epc_d, imm_ext;
    logic            flush_d, ack_d;
    logic            is_br, is_reti, cond_taken, irq_take, redirect;

    assign is_br    = instr_valid && (i[4:3] == OP_BR_MSB);
    assign is_reti  = instr_valid && (i == OP_RETI);
    assign imm_ext  = PC_W'($signed(imm));
    assign irq_take = (state_q == RUN) && irq && flags[FLAG_I];
    // Taken branch or RETI actually redirecting (irq entry pre-empts both)
    assign redirect = !stall && (state_q == RUN) && !irq_take &&
                      ((is_br && cond_taken) || is_reti);

    branch_cond_eval u_cond (
        .flags (flags),
        .cond  (cond_e'(i[2:0])),
        .taken (cond_taken)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        epc_d   = epc;
        flush_d = flush;
        ack_d   = 1'b0;
        if (!stall) begin
            flush_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (irq_take) begin
                        epc_d   = pc;
                        pc_d    = IRQ_VEC;
                        ack_d   = 1'b1;
                        flush_d = 1'b1;
                        state_d = FLUSH;
                    end else if (is_br && cond_taken) begin
                        pc_d    = pc + imm_ext;
                        flush_d = 1'b1;
                        state_d = FLUSH;
                    end else if (is_reti) begin
                        pc_d    = epc;
                        flush_d = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        pc_d = pc + PC_W'(1);
                    end
                end
                FLUSH: begin
                    pc_d    = pc + PC_W'(1);
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc      <= RESET_PC;
            epc     <= '0;
            flush   <= 1'b0;
            irq_ack <= 1'b0;
            clr_i   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            epc     <= epc_d;
            flush   <= flush_d;
            irq_ack <= ack_d;
            clr_i   <= ack_d;
        end
    end

`ifdef FLAG_BRANCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_taken_cnt <= '0;
        end else if (redirect && (br_taken_cnt != 16'hFFFF)) begin
            br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// tb/tb_flag_branch_ctrl.sv - scoreboard bench for flag_branch_ctrl with directed vectors
module tb_flag_branch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, instr_valid, stall, irq;
    logic [4:0] i;
    logic [7:0] imm, flags;
    logic [7:0] pc, epc;
    logic       flush, irq_ack, clr_i;
`ifdef FLAG_BRANCH_PERF_EN
    logic [15:0] br_taken_cnt;
`endif

    typedef struct {
        logic [7:0] pc;
        logic       flush;
        logic       ack;
        logic [7:0] epc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    flag_branch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .i           (i),
        .imm         (imm),
        .flags       (flags),
        .stall       (stall),
        .irq         (irq),
        .pc          (pc),
        .flush       (flush),
        .irq_ack     (irq_ack),
        .clr_i       (clr_i),
        .epc         (epc)
`ifdef FLAG_BRANCH_PERF_EN
        ,
        .br_taken_cnt(br_taken_cnt)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; one expected entry per clock
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", 16'(pc), 16'(e.pc));
            chk("flush", 16'(flush), 16'(e.flush));
            chk("irq_ack", 16'(irq_ack), 16'(e.ack));
            chk("clr_i", 16'(clr_i), 16'(e.ack));
            chk("epc", 16'(epc), 16'(e.epc));
        end
    end

    task automatic cyc(input logic rn, input logic st, input logic iv, input logic [4:0] op,
                       input logic [7:0] im, input logic [7:0] fl, input logic ir,
                       input logic [7:0] e_pc, input logic e_fl, input logic e_ack,
                       input logic [7:0] e_epc);
        exp_t e;
        rst_n = rn; stall = st; instr_valid = iv; i = op; imm = im; flags = fl; irq = ir;
        @(posedge clk);
        e.pc = e_pc; e.flush = e_fl; e.ack = e_ack; e.epc = e_epc;
        q.push_back(e);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; instr_valid = 1'b0; i = '0; imm = '0; flags = '0; irq = 1'b0;
        #1;
        cyc(0,0,0,5'h00,8'h00,8'h00,0, 8'h00,0,0,8'h00);
        cyc(0,0,0,5'h00,8'h00,8'h00,0, 8'h00,0,0,8'h00);
        for (int k = 1; k <= 16; k++)
            cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'(k),0,0,8'h00);
        // conditional branches
        cyc(1,0,1,5'h11,8'h05,8'h21,0, 8'h15,1,0,8'h00);
        cyc(1,0,1,5'h10,8'h20,8'h00,0, 8'h16,0,0,8'h00);
        cyc(1,0,1,5'h11,8'h05,8'h20,0, 8'h17,0,0,8'h00);
        cyc(1,0,1,5'h17,8'hF0,8'h24,0, 8'h07,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h08,0,0,8'h00);
        cyc(1,0,1,5'h17,8'hF0,8'h26,0, 8'h09,0,0,8'h00);
        cyc(1,0,1,5'h13,8'h03,8'h08,0, 8'h0C,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h0D,0,0,8'h00);
        cyc(1,0,1,5'h14,8'h03,8'h08,0, 8'h0E,0,0,8'h00);
        cyc(1,0,1,5'h16,8'h02,8'h02,0, 8'h10,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h11,0,0,8'h00);
        cyc(1,0,1,5'h12,8'h05,8'h01,0, 8'h12,0,0,8'h00);
        cyc(1,0,1,5'h19,8'h05,8'hFF,0, 8'h13,0,0,8'h00);
        cyc(1,0,1,5'h1A,8'h05,8'hFF,0, 8'h14,0,0,8'h00);
        // wrap FE -> FF -> 00
        cyc(1,0,1,5'h10,8'hEA,8'h00,0, 8'hFE,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'hFF,0,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h00,0,0,8'h00);
        cyc(1,0,1,5'h10,8'h3F,8'h00,0, 8'h3F,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h40,0,0,8'h00);
        // interrupt entry with concurrent branch, RETI, masked irq
        cyc(1,0,1,5'h10,8'h10,8'h30,1, 8'hF0,1,1,8'h40);
        cyc(1,0,0,5'h00,8'h00,8'h30,1, 8'hF1,0,0,8'h40);
        cyc(1,0,0,5'h00,8'h00,8'h20,1, 8'hF2,0,0,8'h40);
        cyc(1,0,1,5'h18,8'h00,8'h20,1, 8'h40,1,0,8'h40);
        cyc(1,0,0,5'h00,8'h00,8'h20,1, 8'h41,0,0,8'h40);
        cyc(1,0,0,5'h00,8'h00,8'h20,1, 8'h42,0,0,8'h40);
        // stall around a taken branch and during FLUSH
        for (int k = 0; k < 3; k++)
            cyc(1,1,1,5'h11,8'h08,8'h01,0, 8'h42,0,0,8'h40);
        cyc(1,0,1,5'h11,8'h08,8'h01,0, 8'h4A,1,0,8'h40);
        cyc(1,1,0,5'h00,8'h00,8'h00,0, 8'h4A,1,0,8'h40);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h4B,0,0,8'h40);
        cyc(1,0,1,5'h10,8'h05,8'h00,0, 8'h50,1,0,8'h40);
        cyc(0,0,0,5'h00,8'h00,8'h00,0, 8'h00,0,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h01,0,0,8'h00);
        // 3 taken, 2 not taken, 1 interrupt
        cyc(1,0,1,5'h10,8'h02,8'h00,0, 8'h03,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h04,0,0,8'h00);
        cyc(1,0,1,5'h10,8'h02,8'h00,0, 8'h06,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h07,0,0,8'h00);
        cyc(1,0,1,5'h10,8'h02,8'h00,0, 8'h09,1,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'h0A,0,0,8'h00);
        cyc(1,0,1,5'h11,8'h02,8'h00,0, 8'h0B,0,0,8'h00);
        cyc(1,0,1,5'h13,8'h02,8'h00,0, 8'h0C,0,0,8'h00);
        cyc(1,0,0,5'h00,8'h00,8'h10,1, 8'hF0,1,1,8'h0C);
        cyc(1,0,0,5'h00,8'h00,8'h00,0, 8'hF1,0,0,8'h0C);
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
`ifdef FLAG_BRANCH_PERF_EN
        chk("br_taken_cnt", br_taken_cnt, 16'd3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
